lmem_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single layer-memory port (crd/cwr/csel/caddr_rd/caddr_wr/cdata_wr/cdata_rd) among NREQ datapath requesters, e.g. the conv writer, the max-pool reader/writer and the flatten engine.
- Each requester issues one read or write per handshake. Read data returns to the issuing requester on a shared response bus with a one-hot valid.
- A per-requester lock holds the grant across multi-access sequences, e.g. 4 pool reads followed by 1 write.

---
 rtl/lmem_rr_arbiter_if.sv | 45 ++++
 rtl/lmem_rr_arbiter.sv | 174 +++++++++++++++++
 tb/tb_lmem_rr_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lmem_rr_arbiter_if.sv
// lmem_rr_arbiter_if
//   Bundle of requester handshake, read-response and layer-memory signals
//   shared by lmem_rr_arbiter and its environment.
//   Per-requester fields are packed; requester i owns slice i of each vector.
//   Modports:
//     slave  - the arbiter: takes requests and cdata_rd; drives grants,
//              responses, err/busy and the memory strobes/address/data.
//     master - requesters plus the memory model: the opposite directions.
interface lmem_rr_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 12,
  parameter int DW   = 20,
  parameter int SW   = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*SW-1:0] req_sel;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               err;
  logic               busy;
  logic               crd;
  logic               cwr;
  logic [SW-1:0]      csel;
  logic [AW-1:0]      caddr_rd;
  logic [AW-1:0]      caddr_wr;
  logic [DW-1:0]      cdata_wr;
  logic [DW-1:0]      cdata_rd;

  modport slave (
    input  req_valid, req_we, req_lock, req_sel, req_addr, req_wdata, cdata_rd,
    output req_ready, rsp_valid, rsp_data, err, busy,
           crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr
  );

  modport master (
    output req_valid, req_we, req_lock, req_sel, req_addr, req_wdata, cdata_rd,
    input  req_ready, rsp_valid, rsp_data, err, busy,
           crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr
  );
endinterface

// File: rtl/lmem_rr_arbiter.sv
// lmem_rr_arbiter
//   Round-robin arbiter sharing the single layer-memory port among NREQ
//   requesters. One access per accepted handshake; read data comes back on
//   a shared response bus tagged with a one-hot rsp_valid, two edges after
//   the accept. A requester may lock the grant across a multi-access burst.
//   Ports:
//     clk   - clock, all state on the rising edge
//     reset - synchronous, active-high
//     bus   - lmem_rr_arbiter_if.slave: requests (valid/we/lock/sel/addr/
//             wdata), one-hot combinational req_ready, rsp_valid/rsp_data,
//             err/busy, and the memory port crd/cwr/csel/caddr_rd/caddr_wr/
//             cdata_wr/cdata_rd.
module lmem_rr_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 12,
  parameter int DW   = 20,
  parameter int SW   = 3
) (
  input logic             clk,
  input logic             reset,
  lmem_rr_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            lock_valid_q, lock_valid_d;
  logic [PW-1:0]   lock_owner_q, lock_owner_d;

  logic            s1_valid_q, s2_valid_q;
  logic [PW-1:0]   s1_id_q, s2_id_q;

  logic            crd_q, cwr_q, err_q, busy_q;
  logic [SW-1:0]   csel_q;
  logic [AW-1:0]   caddr_rd_q, caddr_wr_q;
  logic [DW-1:0]   cdata_wr_q, rsp_data_q;
  logic [NREQ-1:0] rsp_valid_q;

  logic            grant_found;
  logic [PW-1:0]   grant_id;
  logic [NREQ-1:0] req_ready;
  logic            we_g, lock_g;
  logic [SW-1:0]   sel_g;
  logic [AW-1:0]   addr_g;
  logic [DW-1:0]   wdata_g;

  // A held lock pins the grant to its owner, even while the owner is idle;
  // otherwise search from ptr upward, wrapping at NREQ.
  always_comb begin
    logic [PW-1:0] cand;
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    if (lock_valid_q) begin
      if (bus.req_valid[lock_owner_q]) begin
        grant_found = 1'b1;
        grant_id    = lock_owner_q;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        cand = PW'((int'(ptr_q) + k) % NREQ);
        if (!grant_found && bus.req_valid[cand]) begin
          grant_found = 1'b1;
          grant_id    = cand;
        end
      end
    end
    req_ready = '0;
    if (grant_found) req_ready[grant_id] = 1'b1;
  end

  // Select the granted requester's fields with constant slice bases.
  always_comb begin
    we_g    = 1'b0;
    lock_g  = 1'b0;
    sel_g   = '0;
    addr_g  = '0;
    wdata_g = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == PW'(i)) begin
        we_g    = bus.req_we[i];
        lock_g  = bus.req_lock[i];
        sel_g   = bus.req_sel[i*SW +: SW];
        addr_g  = bus.req_addr[i*AW +: AW];
        wdata_g = bus.req_wdata[i*DW +: DW];
      end
    end
  end

  // A locked accept keeps ptr where it is; an unlocked accept (including the
  // one that ends a lock) moves ptr just past the granted requester.
  always_comb begin
    ptr_d        = ptr_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    if (grant_found) begin
      if (lock_g) begin
        lock_valid_d = 1'b1;
        lock_owner_d = grant_id;
      end else begin
        lock_valid_d = 1'b0;
        ptr_d = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
      end
    end
  end

  // Strobes are single-cycle; addresses/data/select hold between accepts.
  // A sel = 0 request is consumed with only an err pulse. Reads ride a
  // two-stage tag pipe that lines up with the memory's read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_id_q      <= '0;
      crd_q        <= 1'b0;
      cwr_q        <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      csel_q       <= '0;
      caddr_rd_q   <= '0;
      caddr_wr_q   <= '0;
      cdata_wr_q   <= '0;
      rsp_data_q   <= '0;
      rsp_valid_q  <= '0;
    end else begin
      ptr_q        <= ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      crd_q        <= 1'b0;
      cwr_q        <= 1'b0;
      err_q        <= 1'b0;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= s1_valid_q;
      s2_id_q      <= s1_id_q;
      rsp_valid_q  <= '0;
      if (s2_valid_q) begin
        rsp_valid_q[s2_id_q] <= 1'b1;
        rsp_data_q           <= bus.cdata_rd;
      end
      busy_q <= (|bus.req_valid) | s1_valid_q | s2_valid_q | (|rsp_valid_q);
      if (grant_found) begin
        if (sel_g == '0) begin
          err_q <= 1'b1;
        end else if (we_g) begin
          cwr_q      <= 1'b1;
          caddr_wr_q <= addr_g;
          cdata_wr_q <= wdata_g;
          csel_q     <= sel_g;
        end else begin
          crd_q      <= 1'b1;
          caddr_rd_q <= addr_g;
          csel_q     <= sel_g;
          s1_valid_q <= 1'b1;
          s1_id_q    <= grant_id;
        end
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.crd       = crd_q;
  assign bus.cwr       = cwr_q;
  assign bus.csel      = csel_q;
  assign bus.caddr_rd  = caddr_rd_q;
  assign bus.caddr_wr  = caddr_wr_q;
  assign bus.cdata_wr  = cdata_wr_q;
endmodule

// File: tb/tb_lmem_rr_arbiter.sv
// tb_lmem_rr_arbiter
//   Self-checking bench for lmem_rr_arbiter. A behavioural memory returns a
//   fixed pattern per (sel, addr); each issued read pushes its expected
//   response to a queue that a negedge monitor pops when rsp_valid fires.
module tb_lmem_rr_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 12;
  localparam int DW   = 20;
  localparam int SW   = 3;

  typedef struct {
    logic [NREQ-1:0] id;
    logic [DW-1:0]   data;
  } rspExp_t;

  logic clk;
  logic reset;
  int   checkCount;
  int   errorCount;
  rspExp_t expQ[$];

  lmem_rr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .SW(SW)) bus ();

  lmem_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .SW(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: one planted word, everything else a pattern of sel/addr.
  function automatic logic [DW-1:0] memData(input logic [SW-1:0] sel, input logic [AW-1:0] addr);
    if (sel == 3'd1 && addr == 12'h041) return 20'h0ABCD;
    return {sel, addr, 5'b0} ^ 20'h5A5A5;
  endfunction

  // Memory samples crd/caddr_rd on an edge and presents data the cycle after.
  always @(posedge clk) begin
    if (reset) bus.cdata_rd <= '0;
    else if (bus.crd) bus.cdata_rd <= memData(bus.csel, bus.caddr_rd);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Response scoreboard plus the strobe-exclusion invariant, every cycle.
  always @(negedge clk) begin
    rspExp_t e;
    checkOutput("strobe_excl", 32'(bus.crd & bus.cwr), 32'd0);
    if (bus.rsp_valid != '0) begin
      if (expQ.size() == 0) begin
        checkOutput("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("rsp_id", 32'(bus.rsp_valid), 32'(e.id));
        checkOutput("rsp_data", 32'(bus.rsp_data), 32'(e.data));
      end
    end
  end

  task automatic setReq(input int r, input bit we, input bit lock, input logic [SW-1:0] sel,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus.req_we[r]               = we;
    bus.req_lock[r]             = lock;
    bus.req_sel[r*SW +: SW]     = sel;
    bus.req_addr[r*AW +: AW]    = addr;
    bus.req_wdata[r*DW +: DW]   = wdata;
    bus.req_valid[r]            = 1'b1;
  endtask

  // Drive one request, wait (bounded) for its grant, then check the memory
  // strobes registered at the accept edge. Returns at accept edge + 1.
  task automatic applyStimulus(input int r, input bit we, input bit lock, input logic [SW-1:0] sel,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input bit expectRsp);
    bit granted;
    rspExp_t e;
    setReq(r, we, lock, sel, addr, wdata);
    granted = 1'b0;
    for (int w = 0; w < 20 && !granted; w++) begin
      @(negedge clk);
      if (bus.req_ready[r]) granted = 1'b1;
    end
    checkOutput("grant_wait", 32'(granted), 32'd1);
    if (!granted) begin
      bus.req_valid[r] = 1'b0;
      return;
    end
    checkOutput("ready_onehot", 32'(bus.req_ready), 32'(1 << r));
    @(posedge clk);
    #1;
    bus.req_valid[r] = 1'b0;
    if (sel == '0) begin
      checkOutput("err_pulse", 32'(bus.err), 32'd1);
      checkOutput("err_no_cwr", 32'(bus.cwr), 32'd0);
      checkOutput("err_no_crd", 32'(bus.crd), 32'd0);
    end else if (we) begin
      checkOutput("wr_cwr", 32'(bus.cwr), 32'd1);
      checkOutput("wr_crd", 32'(bus.crd), 32'd0);
      checkOutput("wr_addr", 32'(bus.caddr_wr), 32'(addr));
      checkOutput("wr_data", 32'(bus.cdata_wr), 32'(wdata));
      checkOutput("wr_sel", 32'(bus.csel), 32'(sel));
    end else begin
      checkOutput("rd_crd", 32'(bus.crd), 32'd1);
      checkOutput("rd_cwr", 32'(bus.cwr), 32'd0);
      checkOutput("rd_addr", 32'(bus.caddr_rd), 32'(addr));
      checkOutput("rd_sel", 32'(bus.csel), 32'(sel));
      if (expectRsp) begin
        e.id   = NREQ'(1 << r);
        e.data = memData(sel, addr);
        expQ.push_back(e);
      end
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_crd"}, 32'(bus.crd), 32'd0);
    checkOutput({tag, "_cwr"}, 32'(bus.cwr), 32'd0);
    checkOutput({tag, "_csel"}, 32'(bus.csel), 32'd0);
    checkOutput({tag, "_caddr_rd"}, 32'(bus.caddr_rd), 32'd0);
    checkOutput({tag, "_caddr_wr"}, 32'(bus.caddr_wr), 32'd0);
    checkOutput({tag, "_cdata_wr"}, 32'(bus.cdata_wr), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    checkOutput({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_lock  = '0;
    bus.req_sel   = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset state
    doReset();
    checkAllZero("reset");
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);

    // Single read with two-edge latency
    applyStimulus(0, 1'b0, 1'b0, 3'd1, 12'h041, 20'h0, 1'b1);
    @(posedge clk); #1;
    checkOutput("rd_crd_drop", 32'(bus.crd), 32'd0);
    checkOutput("rd_lat_e1", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("rd_lat_e2_valid", 32'(bus.rsp_valid), 32'b001);
    checkOutput("rd_lat_e2_data", 32'(bus.rsp_data), 32'h0ABCD);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy_idle", 32'(bus.busy), 32'd0);

    // Round-robin among three writers from ptr = 0
    doReset();
    for (int i = 0; i < NREQ; i++)
      setReq(i, 1'b1, 1'b0, SW'(i + 1), AW'(12'h100 + i), DW'(20'h10000 + i * 16'h1111));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("rr_grant", 32'(bus.req_ready), 32'(1 << (k % NREQ)));
      @(posedge clk); #1;
      checkOutput("rr_cwr", 32'(bus.cwr), 32'd1);
      checkOutput("rr_addr", 32'(bus.caddr_wr), 32'(12'h100 + (k % NREQ)));
      checkOutput("rr_data", 32'(bus.cdata_wr), 32'(20'h10000 + (k % NREQ) * 16'h1111));
    end
    bus.req_valid = '0;
    @(posedge clk); #1;
    checkOutput("rr_cwr_drop", 32'(bus.cwr), 32'd0);

    // Lock burst by requester 1 while 0 and 2 wait (ptr moved to 1 first)
    applyStimulus(0, 1'b1, 1'b0, 3'd1, 12'h300, 20'h00300, 1'b0);
    setReq(0, 1'b1, 1'b0, 3'd1, 12'h301, 20'h00001);
    setReq(2, 1'b1, 1'b0, 3'd2, 12'h302, 20'h00002);
    for (int k = 0; k < 2; k++)
      applyStimulus(1, 1'b0, 1'b1, 3'd2, AW'(12'h010 + k), 20'h0, 1'b1);
    @(negedge clk);
    checkOutput("lock_hold_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("lock_hold_no_crd", 32'(bus.crd), 32'd0);
    for (int k = 2; k < 4; k++)
      applyStimulus(1, 1'b0, 1'b1, 3'd2, AW'(12'h010 + k), 20'h0, 1'b1);
    applyStimulus(1, 1'b1, 1'b0, 3'd3, 12'h020, 20'h00F00, 1'b0);
    @(negedge clk);
    checkOutput("unlock_next_grant", 32'(bus.req_ready), 32'b100);
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b0;
    checkOutput("unlock_wr_addr", 32'(bus.caddr_wr), 32'h302);
    @(negedge clk);
    checkOutput("unlock_then_req0", 32'(bus.req_ready), 32'b001);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;

    // Pipelined read, read, write on consecutive cycles
    applyStimulus(0, 1'b0, 1'b0, 3'd1, 12'h005, 20'h0, 1'b1);
    applyStimulus(2, 1'b0, 1'b0, 3'd2, 12'h009, 20'h0, 1'b1);
    applyStimulus(1, 1'b1, 1'b0, 3'd4, 12'h0AA, 20'h12345, 1'b0);
    checkOutput("pipe_rsp0_id", 32'(bus.rsp_valid), 32'b001);
    checkOutput("pipe_rsp0_data", 32'(bus.rsp_data), 32'(memData(3'd1, 12'h005)));
    @(posedge clk); #1;
    checkOutput("pipe_rsp1_id", 32'(bus.rsp_valid), 32'b100);
    checkOutput("pipe_rsp1_data", 32'(bus.rsp_data), 32'(memData(3'd2, 12'h009)));
    repeat (2) @(posedge clk);
    #1;

    // Invalid sel: consumed with err, ptr advances past requester 0
    applyStimulus(0, 1'b1, 1'b0, 3'd0, 12'h055, 20'h00777, 1'b0);
    setReq(0, 1'b1, 1'b0, 3'd1, 12'h060, 20'h00060);
    setReq(1, 1'b1, 1'b0, 3'd1, 12'h061, 20'h00061);
    @(negedge clk);
    checkOutput("ptr_after_err", 32'(bus.req_ready), 32'b010);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    checkOutput("err_one_cycle", 32'(bus.err), 32'd0);
    @(negedge clk);
    checkOutput("err_then_req0", 32'(bus.req_ready), 32'b001);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset one edge after a locked read accept
    applyStimulus(0, 1'b0, 1'b1, 3'd1, 12'h041, 20'h0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    checkAllZero("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req_valid = 3'b110;
    #1;
    checkOutput("midrst_lock_dropped", 32'(bus.req_ready), 32'b010);
    bus.req_valid = 3'b111;
    #1;
    checkOutput("midrst_ptr_zero", 32'(bus.req_ready), 32'b001);
    bus.req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);

    checkOutput("rsp_queue_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
